// File: rtl/fifo_pkg.sv
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Shared defaults, thresholds and types for the fifo slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    localparam int FIFO_DATA_WIDTH      = 8;
    localparam int FIFO_DEPTH           = 16;
    localparam int PTR_W                = $clog2(FIFO_DEPTH);
    localparam int FIFO_ALMOST_FULL_TH  = 14;
    localparam int FIFO_ALMOST_EMPTY_TH = 2;

    typedef logic [FIFO_DATA_WIDTH-1:0] data_t;

endpackage : fifo_pkg

`default_nettype wire

// File: rtl/fifo_if.sv
// ============================================================================
// Module   : fifo_if
// Purpose  : Bundle of every fifo port except the clock, which is passed in.
//            Carries overflow/underflow when FIFO_ERR_FLAGS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
)(
    input logic clk
);

    logic                  rst;
    logic                  wr_enb;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_enb;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  half;
`ifdef FIFO_ERR_FLAGS_EN
    logic                  overflow;
    logic                  underflow;
`endif

    modport dut (
        input  clk, rst, wr_enb, wr_data, rd_enb,
        output rd_data, full, empty, almost_full, almost_empty, half
`ifdef FIFO_ERR_FLAGS_EN
        , output overflow, underflow
`endif
    );

    modport drv (
        input  clk, rd_data, full, empty, almost_full, almost_empty, half,
        output rst, wr_enb, wr_data, rd_enb
`ifdef FIFO_ERR_FLAGS_EN
        , input overflow, underflow
`endif
    );

endinterface : fifo_if

`default_nettype wire

// File: rtl/fifo_mem.sv
// ============================================================================
// Module   : fifo_mem
// Purpose  : DEPTH x DATA_WIDTH RAM, synchronous write, registered read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH,
    parameter int ADDR_W     = $clog2(DEPTH)
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Array is deliberately left without reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule : fifo_mem

`default_nettype wire

// File: rtl/fifo.sv
// ============================================================================
// Module   : fifo
// Purpose  : Single-clock synchronous FIFO with occupancy flags. Defining
//            FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH      = FIFO_DATA_WIDTH,
    parameter int DEPTH           = FIFO_DEPTH,
    parameter int ALMOST_FULL_TH  = FIFO_ALMOST_FULL_TH,
    parameter int ALMOST_EMPTY_TH = FIFO_ALMOST_EMPTY_TH
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  half
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_half    = c_cnt_w'(DEPTH / 2);
    localparam logic [c_cnt_w-1:0] c_af_th   = c_cnt_w'(ALMOST_FULL_TH);
    localparam logic [c_cnt_w-1:0] c_ae_th   = c_cnt_w'(ALMOST_EMPTY_TH);

    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic w_wr_acc;
    logic w_rd_acc;
    logic w_mem_we;

    assign w_wr_acc = wr_en & ~full;
    assign w_rd_acc = rd_en & ~empty;
    // Reset outranks a coincident write, so the RAM never sees it.
    assign w_mem_we = w_wr_acc & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    assign full         = (r_count == c_depth);
    assign empty        = (r_count == '0);
    assign almost_full  = (r_count >= c_af_th);
    assign almost_empty = (r_count <= c_ae_th);
    assign half         = (r_count >= c_half);

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (c_ptr_w)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_mem_we),
        .wr_addr (r_wr_ptr),
        .wr_data (wr_data),
        .rd_en   (w_rd_acc),
        .rd_addr (r_rd_ptr),
        .rd_data (rd_data)
    );

`ifdef FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule : fifo

`default_nettype wire

// File: tb/tb_fifo.sv
// ============================================================================
// Module   : tb_fifo
// Purpose  : Directed self-checking bench for fifo (default 8 x 16 build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo;
    import fifo_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    fifo_if #(.DATA_WIDTH(FIFO_DATA_WIDTH)) bus (.clk(clk));

    fifo #(
        .DATA_WIDTH      (FIFO_DATA_WIDTH),
        .DEPTH           (FIFO_DEPTH),
        .ALMOST_FULL_TH  (FIFO_ALMOST_FULL_TH),
        .ALMOST_EMPTY_TH (FIFO_ALMOST_EMPTY_TH)
    ) dut (
        .clk          (clk),
        .rst          (bus.rst),
        .wr_en        (bus.wr_enb),
        .wr_data      (bus.wr_data),
        .rd_en        (bus.rd_enb),
        .rd_data      (bus.rd_data),
        .full         (bus.full),
        .empty        (bus.empty),
        .almost_full  (bus.almost_full),
        .almost_empty (bus.almost_empty),
        .half         (bus.half)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .overflow     (bus.overflow),
        .underflow    (bus.underflow)
`endif
    );

    int n_vec  = 0;
    int n_miss = 0;
    logic [PTR_W:0] r_cnt;   // model occupancy

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Flags and internal occupancy are checked against the model count.
    task automatic chk_state(input string tag);
        chk({tag, ".count"}, 32'(dut.r_count), 32'(r_cnt));
        chk({tag, ".empty"}, 32'(bus.empty), 32'(r_cnt == 0));
        chk({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(r_cnt <= 2));
        chk({tag, ".half"}, 32'(bus.half), 32'(r_cnt >= 8));
        chk({tag, ".almost_full"}, 32'(bus.almost_full), 32'(r_cnt >= 14));
        chk({tag, ".full"}, 32'(bus.full), 32'(r_cnt == 16));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic wr, input logic [7:0] d, input logic rd);
        bus.wr_enb  = wr;
        bus.wr_data = d;
        bus.rd_enb  = rd;
        step();
        bus.wr_enb  = 1'b0;
        bus.rd_enb  = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        xfer(1'b1, d, 1'b0);
        if (r_cnt != 16) r_cnt++;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        xfer(1'b0, 8'h00, 1'b1);
        if (r_cnt != 0) r_cnt--;
        chk(tag, 32'(bus.rd_data), 32'(exp));
    endtask

    initial begin
        bus.rst     = 1'b1;
        bus.wr_enb  = 1'b0;
        bus.wr_data = '0;
        bus.rd_enb  = 1'b0;
        r_cnt       = '0;

        // Reset held two cycles
        step();
        step();
        bus.rst = 1'b0;
        chk_state("reset");
        chk("reset.rd_data", 32'(bus.rd_data), 32'h0);

        // Fill 0x01..0x10, flags tracked per write
        for (int i = 1; i <= 16; i++) begin
            push(8'(i));
            chk_state($sformatf("fill%0d", i));
        end
        push(8'hFF);
        chk_state("fill_over");

        // Drain in order; the 0xFF must never appear
        for (int i = 1; i <= 16; i++) begin
            pop_chk($sformatf("drain%0d.data", i), 8'(i));
            chk_state($sformatf("drain%0d", i));
        end
        pop_chk("drain_under.data", 8'h10);
        chk_state("drain_under");

        // Concurrent read/write at count 5
        for (int i = 0; i < 5; i++) push(8'h21 + 8'(i));
        for (int i = 0; i < 4; i++) begin
            xfer(1'b1, 8'h26 + 8'(i), 1'b1);
            chk($sformatf("simul%0d.data", i), 32'(bus.rd_data), 32'(8'h21 + 8'(i)));
            chk_state($sformatf("simul%0d", i));
        end
        for (int i = 0; i < 5; i++) pop_chk($sformatf("simul_drain%0d", i), 8'h25 + 8'(i));
        chk_state("simul_drained");

        // Full: only the read is taken
        for (int i = 0; i < 16; i++) push(8'h30 + 8'(i));
        chk_state("full_pre");
        xfer(1'b1, 8'h77, 1'b1);
        r_cnt = 15;
        chk("full_rw.data", 32'(bus.rd_data), 32'h30);
        chk_state("full_rw");
        for (int i = 1; i < 16; i++) pop_chk($sformatf("full_drain%0d", i), 8'h30 + 8'(i));
        chk_state("full_drained");

        // Empty: only the write is taken, no fall-through
        xfer(1'b1, 8'h88, 1'b1);
        r_cnt = 1;
        chk("empty_rw.data", 32'(bus.rd_data), 32'h3F);
        chk_state("empty_rw");
        pop_chk("empty_rw_pop", 8'h88);
        chk_state("empty_rw_done");

        // Pointer wrap
        for (int i = 0; i < 10; i++) push(8'h40 + 8'(i));
        for (int i = 0; i < 10; i++) pop_chk($sformatf("wrap_a%0d", i), 8'h40 + 8'(i));
        for (int i = 0; i < 16; i++) push(8'hA0 + 8'(i));
        chk_state("wrap_full");
        for (int i = 0; i < 16; i++) pop_chk($sformatf("wrap_b%0d", i), 8'hA0 + 8'(i));
        chk_state("wrap_empty");

`ifdef FIFO_ERR_FLAGS_EN
        chk("err.overflow", 32'(bus.overflow), 32'h1);
        chk("err.underflow", 32'(bus.underflow), 32'h1);
`endif

        // Reset mid-operation at count 7
        for (int i = 0; i < 7; i++) push(8'h60 + 8'(i));
        chk_state("mid_pre");
        bus.rst = 1'b1;
        xfer(1'b1, 8'h99, 1'b1);
        bus.rst = 1'b0;
        r_cnt = 0;
        chk_state("mid_rst");
        chk("mid_rst.rd_data", 32'(bus.rd_data), 32'h0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("mid_rst.overflow", 32'(bus.overflow), 32'h0);
        chk("mid_rst.underflow", 32'(bus.underflow), 32'h0);
`endif
        push(8'h55);
        chk_state("mid_push");
        pop_chk("mid_pop", 8'h55);
        chk_state("mid_done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_fifo

`default_nettype wire
